// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin owner arbitration for a shared datapath unit with hold-limit timeout
module rr_resource_arbiter #(
  parameter int REQ_COUNT = 8,
  parameter int MAX_HOLD = 15,
  localparam int IDX_WIDTH = $clog2(REQ_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_COUNT-1:0] req,
  input  logic                 done,
  output logic [REQ_COUNT-1:0] grant,
  output logic                 grant_valid,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 timeout
);
  localparam int HCW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic [IDX_WIDTH-1:0] ptr, ptr_n, idx_n;
  logic [HCW-1:0] hold_cnt, hold_cnt_n;
  logic [REQ_COUNT-1:0] cand, hi_mask, hi, pick, grant_n;
  logic owner_req, rel;
  always_comb begin
    owner_req = |(req & grant);
    timeout = state == HOLD && owner_req && !done && MAX_HOLD != 0 && hold_cnt == HOLD_LAST;
    rel = state == IDLE || !owner_req || done || timeout;
    cand = timeout ? req & ~grant : req;
    for (int i = 0; i < REQ_COUNT; i++) hi_mask[i] = i > int'(ptr);
    hi = cand & hi_mask;
    // lowest set bit of the upper window, else wrap to the lowest set bit overall
    pick = hi != '0 ? hi & (~hi + REQ_COUNT'(1)) : cand & (~cand + REQ_COUNT'(1));
    grant_n = rel ? pick : grant;
    state_n = grant_n != '0 ? HOLD : IDLE;
    idx_n = '0;
    for (int i = 0; i < REQ_COUNT; i++) if (grant_n[i]) idx_n = IDX_WIDTH'(i);
    ptr_n = rel && pick != '0 ? idx_n : ptr;
    hold_cnt_n = rel ? '0 : hold_cnt + HCW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      grant_valid <= 1'b0;
      grant_idx <= '0;
      ptr <= IDX_WIDTH'(REQ_COUNT - 1);
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_valid <= |grant_n;
      grant_idx <= idx_n;
      ptr <= ptr_n;
      hold_cnt <= hold_cnt_n;
    end
  end
endmodule
